// File: rtl/motion_pkg.sv
// Shared key codes, FSM encoding and bit positions for the motion scheduler.
package motion_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h61;
  localparam logic [7:0] KEY_RIGHT = 8'h64;
  localparam logic [7:0] KEY_FWD   = 8'h77;
  localparam logic [7:0] KEY_BACK  = 8'h73;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // Bit positions inside the 2-bit rotate/move fields.
  localparam int ROT_L = 1;
  localparam int ROT_R = 0;
  localparam int MV_F  = 1;
  localparam int MV_B  = 0;

  // Positions inside the 4-bit {L,R,F,B} held/tap vectors.
  localparam int KB_L = 2 + ROT_L;
  localparam int KB_R = 2 + ROT_R;
  localparam int KB_F = MV_F;
  localparam int KB_B = MV_B;

  // Opposing keys in the same pair cancel each other out.
  function automatic logic [1:0] resolve_pair(input logic [1:0] pair);
    return (pair == 2'b11) ? 2'b00 : pair;
  endfunction

endpackage

// File: rtl/key_tracker.sv
// Tracks held keys and latched taps for the four motion keys {L,R,F,B}.
module key_tracker
  import motion_pkg::*;
#(
  parameter int KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             key_release,
  input  logic [3:0]       tap_clr,
  output logic [3:0]       held,
  output logic [3:0]       tap
);

  logic [3:0] hit;
  logic [3:0] press;

  always_comb begin
    hit = '0;
    if (key_valid) begin
      if (key_code == KEY_W'(KEY_LEFT))  hit[KB_L] = 1'b1;
      if (key_code == KEY_W'(KEY_RIGHT)) hit[KB_R] = 1'b1;
      if (key_code == KEY_W'(KEY_FWD))   hit[KB_F] = 1'b1;
      if (key_code == KEY_W'(KEY_BACK))  hit[KB_B] = 1'b1;
    end
    press = key_release ? 4'b0000 : hit;
  end

  // A press in the same cycle as a clear wins, so a tap is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      tap  <= '0;
    end else begin
      held <= key_release ? (held & ~hit) : (held | hit);
      tap  <= (tap & ~tap_clr) | press;
    end
  end

endmodule

// File: rtl/motion_scheduler.sv
// Turns tracked key state into one camera motion command per rendered frame.
module motion_scheduler
  import motion_pkg::*;
#(
  parameter int KEY_W         = 8,
  parameter int REPEAT_FRAMES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             key_release,
  input  logic             frame_done,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       rotate_sig,
  output logic [1:0]       move_sig,
  output logic             busy
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // while cmd_valid && !cmd_ready the command and its outputs hold still.

  state_t           state;
  state_t           state_n;
  logic [3:0]       held;
  logic [3:0]       tap;
  logic [3:0]       raw;
  logic [3:0]       tap_clr;
  logic [1:0]       rot_eff;
  logic [1:0]       mv_eff;
  logic [1:0]       rot_q;
  logic [1:0]       mv_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  key_tracker #(.KEY_W(KEY_W)) u_key_tracker (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .tap_clr     (tap_clr),
    .held        (held),
    .tap         (tap)
  );

  always_comb begin
    raw     = held | tap;
    rot_eff = resolve_pair(raw[3:2]);
    mv_eff  = resolve_pair(raw[1:0]);
    cnt_inc = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (frame_done && ({rot_eff, mv_eff} != 4'b0000)) state_n = ISSUE;
      ISSUE:   if (cmd_ready) state_n = (REPEAT_FRAMES == 0) ? IDLE : HOLDOFF;
      HOLDOFF: if (frame_done && (cnt_inc == CNT_W'(REPEAT_FRAMES))) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid  = (state == ISSUE);
    busy       = (state != IDLE);
    rotate_sig = cmd_valid ? rot_q : 2'b00;
    move_sig   = cmd_valid ? mv_q  : 2'b00;
    // Every frame seen in IDLE consumes the taps, issued or cancelled alike.
    tap_clr    = (state == IDLE && frame_done) ? 4'b1111 : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q <= '0;
      mv_q  <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && frame_done && ({rot_eff, mv_eff} != 4'b0000)) begin
        rot_q <= rot_eff;
        mv_q  <= mv_eff;
      end
      if (state == ISSUE && cmd_ready) begin
        cnt <= '0;
      end else if (state == HOLDOFF && frame_done && (cnt != '1)) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule
